// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// big-endian lane bit positions within a memory word.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } lsu_state_e;

    // Big-endian: the lowest byte address lands in the most significant bits.
    localparam int unsigned BYTE0_LSB = 24;
    localparam int unsigned BYTE1_LSB = 16;
    localparam int unsigned BYTE2_LSB = 8;
    localparam int unsigned BYTE3_LSB = 0;
    localparam int unsigned HALF0_LSB = 16;
    localparam int unsigned HALF2_LSB = 0;

endpackage

// File: rtl/load_store_unit_if.sv
// Bus bundles for the load/store unit: the EX/WB request-response side and
// the word-wide data-memory side.
interface lsu_req_if #(parameter int ADDR_W = 10);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface lsu_mem_if #(parameter int ADDR_W = 10);
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_write;
    logic              mem_read;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_write, mem_read,
        input  mem_rdata
    );
    modport slave (
        input  mem_addr, mem_wdata, mem_write, mem_read,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extract/extend, store lane merge and the
// alignment/size legality check.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        unsigned_i,
    input  logic [31:0] word_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o,
    output logic        misaligned_o,
    output logic        illegal_o
);

    logic [1:0]  lane_eff;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign illegal_o    = (size_i == SZ_ILLEGAL);
    assign misaligned_o = ((size_i == SZ_HALF) && lane_i[0]) ||
                          ((size_i == SZ_WORD) && (lane_i != 2'b00));

    // Masking is a no-op for aligned accesses, so it also covers the
    // unchecked configuration where low address bits are simply dropped.
    always_comb begin
        lane_eff = lane_i;
        if (size_i == SZ_HALF) begin
            lane_eff = {lane_i[1], 1'b0};
        end else if (size_i == SZ_WORD) begin
            lane_eff = 2'b00;
        end
    end

    always_comb begin
        byte_v = word_i[BYTE0_LSB +: 8];
        case (lane_eff)
            2'b00:   byte_v = word_i[BYTE0_LSB +: 8];
            2'b01:   byte_v = word_i[BYTE1_LSB +: 8];
            2'b10:   byte_v = word_i[BYTE2_LSB +: 8];
            default: byte_v = word_i[BYTE3_LSB +: 8];
        endcase
        half_v = lane_eff[1] ? word_i[HALF2_LSB +: 16] : word_i[HALF0_LSB +: 16];
    end

    always_comb begin
        load_data_o = word_i;
        case (size_i)
            SZ_BYTE: load_data_o = unsigned_i ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            SZ_HALF: load_data_o = unsigned_i ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            default: load_data_o = word_i;
        endcase
    end

    always_comb begin
        merged_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                case (lane_eff)
                    2'b00:   merged_o[BYTE0_LSB +: 8] = wdata_i[7:0];
                    2'b01:   merged_o[BYTE1_LSB +: 8] = wdata_i[7:0];
                    2'b10:   merged_o[BYTE2_LSB +: 8] = wdata_i[7:0];
                    default: merged_o[BYTE3_LSB +: 8] = wdata_i[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane_eff[1]) begin
                    merged_o[HALF2_LSB +: 16] = wdata_i;
                end else begin
                    merged_o[HALF0_LSB +: 16] = wdata_i;
                end
            end
            default: merged_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word requests into aligned word accesses
// on a big-endian memory, with read-modify-write for sub-word stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    lsu_req_if.slave   req,
    lsu_mem_if.master  mem
);

    lsu_state_e state_q, state_d;

    logic [1:0]        size_q, lane_q;
    logic              write_q, uns_q;
    logic [15:0]       wdata_q;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;

    logic              accept, req_err;
    logic [1:0]        al_size, al_lane;
    logic [31:0]       load_data, merged;
    logic              misaligned, illegal;

    assign accept  = (state_q == ST_IDLE) && req.req_valid;
    // Legality is judged on the live request in IDLE; lane work later uses
    // the captured copy, since request inputs may change after accept.
    assign al_size = (state_q == ST_IDLE) ? req.req_size      : size_q;
    assign al_lane = (state_q == ST_IDLE) ? req.req_addr[1:0] : lane_q;
    assign req_err = illegal || (ALIGN_CHECK && misaligned);

    lsu_lane_align u_lane_align (
        .size_i       (al_size),
        .lane_i       (al_lane),
        .unsigned_i   (uns_q),
        .word_i       (mem.mem_rdata),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .merged_o     (merged),
        .misaligned_o (misaligned),
        .illegal_o    (illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_d = ST_RESP;
                    end else if (req.req_write && (req.req_size == SZ_WORD)) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD:   state_d = write_q ? ST_WR : ST_RESP;
            ST_WR:   state_d = ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs; memory strobes follow the
    // next state so they are flop outputs aligned with RD/WR.
    always_comb begin
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_read_d   = (state_d == ST_RD);
        mem_write_d  = (state_d == ST_WR);
        resp_valid_d = (state_d == ST_RESP);
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mem_addr_d = {req.req_addr[ADDR_W-1:2], 2'b00};
                    resp_err_d = req_err;
                    if (req.req_write && (req.req_size == SZ_WORD)) begin
                        mem_wdata_d = req.req_wdata;
                    end
                end
            end
            ST_RD: begin
                if (write_q) begin
                    mem_wdata_d = merged;
                end else begin
                    resp_rdata_d = load_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            size_q       <= SZ_BYTE;
            lane_q       <= 2'b00;
            write_q      <= 1'b0;
            uns_q        <= 1'b0;
            wdata_q      <= 16'h0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            if (accept) begin
                size_q  <= req.req_size;
                lane_q  <= req.req_addr[1:0];
                write_q <= req.req_write;
                uns_q   <= req.req_unsigned;
                wdata_q <= req.req_wdata[15:0];
            end
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req.req_ready  = (state_q == ST_IDLE);
    assign req.resp_valid = resp_valid_q;
    assign req.resp_err   = resp_err_q;
    assign req.resp_rdata = resp_rdata_q;
    assign mem.mem_addr   = mem_addr_q;
    assign mem.mem_wdata  = mem_wdata_q;
    assign mem.mem_read   = mem_read_q;
    assign mem.mem_write  = mem_write_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the data memory and is its only driver.
- Turns EX-stage load/store requests (byte, half, word; signed or unsigned loads) into word-wide memory accesses.
- The memory is big-endian, byte-addressed and word-wide: address A holds bits 31:24, A+3 holds bits 7:0.
- Sub-word stores use a read-modify-write sequence. Results go back to the WB path through a one-cycle response pulse.

Parameters:
- ADDR_W, 10, byte-address width; memory depth is 2^ADDR_W bytes.
- ALIGN_CHECK, 1, 1 = misaligned half/word requests are flagged as errors; 0 = the low address bits are masked and the access proceeds.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as an error
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  request was rejected (misaligned or illegal size); valid with resp_valid
- mem_addr  out  ADDR_W  word-aligned address to the memory (low 2 bits always 00)
- mem_wdata  out  32  word to write
- mem_write  out  1  write strobe
- mem_read  out  1  read enable
- mem_rdata  in  32  combinational read data from the memory

Behaviour:
- Reset values: all outputs 0, except req_ready=1 (state IDLE). Reset takes priority over every other event.
- All mem_* outputs are registered. The memory is level-sensitive, so these outputs must never glitch.
- A request is accepted on any clk edge where req_valid && req_ready. The unit then captures addr, size, write, unsigned and wdata; no request inputs are used after that.
- Definitions: lane = addr[1:0]; aligned word address = {addr[ADDR_W-1:2], 2'b00}.
  - Byte lane k occupies bits 31-8k : 24-8k.
  - Halfword lane 0 = bits 31:16, lane 2 = bits 15:0.
- Alignment: half with addr[0]=1, word with addr[1:0]!=0, or size 11 is an error.
  - Error with ALIGN_CHECK=1: go IDLE->RESP with no memory strobe; resp_err=1, resp_rdata=0.
- States: IDLE, RD, WR, RESP.
  - IDLE: on accept, go to RESP for an error, WR for a word store, RD for a load or sub-word store.
  - RD: mem_read=1, mem_addr = aligned word address. At the end of the cycle the unit captures mem_rdata.
    - Load: RD->RESP.
    - Sub-word store: RD->WR, with the merged word computed from the captured data.
  - WR: mem_write=1 for exactly one cycle. mem_wdata is either req_wdata (word store) or the merged word, where only the target lane(s) are replaced by the low byte/half of req_wdata. Then WR->RESP.
  - RESP: resp_valid=1 for one cycle, then RESP->IDLE.
    - Load: resp_rdata = the extracted lane, sign- or zero-extended.
    - There is no response backpressure.
- Latency, with the accept edge at cycle 0 and the resp_valid cycle listed:
  - Load: RD at cycle 1, resp_valid at cycle 2.
  - Word store: WR at cycle 1, resp_valid at cycle 2.
  - Sub-word store: RD at 1, WR at 2, resp_valid at 3.
  - Error: resp_valid at cycle 1.
- Throughput: req_ready is low from the accept cycle until IDLE is re-entered. req_valid during RD/WR/RESP is ignored, and the requester must hold it.
- Concurrency: mem_read and mem_write are never high in the same cycle.
- Reset mid-operation:
  - Reset in RD: the write never occurs and memory is unchanged.
  - Reset in WR: the strobe drops at the reset edge and the single write stands.
  - In both cases no resp_valid is produced.
- Top of memory: aligned word address 2^ADDR_W-4 is legal. Addresses never wrap, since all accesses are aligned.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - the state enum (IDLE/RD/WR/RESP);
  - lane bit-position constants.
- One combinational sub-module, lsu_lane_align, provides:
  - extract + sign/zero-extend for loads;
  - lane merge for stores;
  - the misalignment check.
- The FSM and registers stay in load_store_unit.

Test Plan:
- Memory preloaded with word 996 = 0x00000005.
  - lw 996 -> resp_valid at cycle 2, rdata 0x00000005, err 0.
  - lb 999 -> rdata 0x00000005.
- sb 998 with wdata 0x12345680 -> mem_read at cycle 1, mem_write at cycle 2 with mem_wdata 0x00008005, resp at cycle 3. Then:
  - lb 998 -> 0xFFFFFF80;
  - lbu 998 -> 0x00000080;
  - lw 996 -> 0x00008005.
- sh 1022 with wdata 0x0000BEEF -> word 1020 = 0x0000BEEF. Then:
  - lh 1022 -> 0xFFFFBEEF;
  - lhu 1022 -> 0x0000BEEF.
- lw 998 and lh 997 -> each gives resp_err=1, rdata 0, resp at cycle 1, and no mem_read/mem_write pulse at any cycle.
- Back-to-back: req_valid held high with two sw requests -> second accepted only after the first resp_valid; req_ready is low during WR/RESP.
- Reset mid-operation:
  - sb 996 of 0xFF, reset asserted in RD -> no mem_write, no resp_valid, word 996 unchanged, req_ready=1 after reset.
  - reset asserted in WR -> mem_write deasserts at the reset edge.
